canxl_crc_unit: RTL and testbench

Parametrised serial CRC engine for the CAN XL receive and transmit paths. It generalises the fixed 13-bit preface-CRC accumulator so one block can serve PCRC (13-bit, 0x19C7), FCRC (32-bit) or CAN-SEC MAC-preface checks. It folds one bit per received-bit-counter change, and skips stuff bits when told to. It also owns a frame state machine with a registered compare against the received CRC field, which gives the frame-check FSM a single `crc_ok` verdict.

---
 rtl/canxl_crc_unit.sv | 124 ++++++++++++
 tb/tb_canxl_crc_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/canxl_crc_unit.sv
// rtl/canxl_crc_unit.sv - parametrised serial CRC engine with frame FSM and registered compare
//
// Ports:
//   clk, g_rst   clock; asynchronous active-high reset
//   data         serial bit to fold
//   bit_cnt      received-bit counter; a change of value marks a new bit
//   start        begin a frame (re-inits CRC and counters)
//   accum_en     field window; bits are folded only while high
//   stuff_bit    current bit is a stuff bit and is not folded
//   check_req    CRC field complete; compare against rx_crc
//   rx_crc       received CRC field
//   abort        tx/rx success or error; return to IDLE
//   crc_out      running CRC (frozen in DONE)
//   crc_valid    compare verdict available
//   crc_ok       registered compare verdict
//   busy         state is ACCUM
//   bits_folded  bits folded since start, saturating

module canxl_crc_unit #(
  parameter int               CRC_W = 13,
  parameter logic [CRC_W-1:0] POLY  = 13'h19C7,
  parameter logic [CRC_W-1:0] INIT  = '0,
  parameter int               CNT_W = 15
) (
  input  logic             clk,
  input  logic             g_rst,
  input  logic             data,
  input  logic [CNT_W-1:0] bit_cnt,
  input  logic             start,
  input  logic             accum_en,
  input  logic             stuff_bit,
  input  logic             check_req,
  input  logic [CRC_W-1:0] rx_crc,
  input  logic             abort,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_valid,
  output logic             crc_ok,
  output logic             busy,
  output logic [CNT_W-1:0] bits_folded
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [CRC_W-1:0] crc;
  logic [CNT_W-1:0] prev_cnt;
  logic             feedback;
  logic [CRC_W-1:0] crc_next;
  logic             strobe;

  // One step of the MSB-first serial LFSR.
  always_comb begin
    feedback = data ^ crc[CRC_W-1];
    crc_next = {crc[CRC_W-2:0], 1'b0} ^ (feedback ? POLY : '0);
  end

  // A new bit is a counter change; prev_cnt tracks every cycle in ACCUM so a
  // held counter value can only ever fold once.
  assign strobe = accum_en && (bit_cnt != prev_cnt) && !stuff_bit;

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state       <= IDLE;
      crc         <= INIT;
      crc_valid   <= 1'b0;
      crc_ok      <= 1'b0;
      bits_folded <= '0;
      prev_cnt    <= '0;
    end else if (abort) begin
      state       <= IDLE;
      crc         <= INIT;
      crc_valid   <= 1'b0;
      crc_ok      <= 1'b0;
      bits_folded <= '0;
      prev_cnt    <= bit_cnt;
    end else begin
      case (state)
        IDLE: begin
          crc         <= INIT;
          crc_valid   <= 1'b0;
          crc_ok      <= 1'b0;
          bits_folded <= '0;
          if (start) begin
            state    <= ACCUM;
            prev_cnt <= bit_cnt;
          end
        end
        ACCUM: begin
          prev_cnt <= bit_cnt;
          if (start) begin
            crc         <= INIT;
            bits_folded <= '0;
          end else if (check_req) begin
            // A strobe coinciding with check_req is dropped; compare the
            // CRC as it stands before that bit.
            state     <= DONE;
            crc_valid <= 1'b1;
            crc_ok    <= (crc == rx_crc);
          end else if (strobe) begin
            crc <= crc_next;
            if (bits_folded != '1) begin
              bits_folded <= bits_folded + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state       <= ACCUM;
            crc         <= INIT;
            crc_valid   <= 1'b0;
            crc_ok      <= 1'b0;
            bits_folded <= '0;
            prev_cnt    <= bit_cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign crc_out = crc;
  assign busy    = (state == ACCUM);

endmodule

// File: tb/tb_canxl_crc_unit.sv
// tb/tb_canxl_crc_unit.sv - scoreboard bench for canxl_crc_unit (PCRC-13 and CRC-32 instances)

module tb_canxl_crc_unit;

  logic        clk = 1'b0;
  logic        g_rst = 1'b1;
  logic        data = 1'b0;
  logic [14:0] bit_cnt = '0;
  logic        start = 1'b0;
  logic        accum_en = 1'b0;
  logic        stuff_bit = 1'b0;
  logic        check_req = 1'b0;
  logic [12:0] rx_crc = '0;
  logic [31:0] rx_crc32 = '0;
  logic        abort = 1'b0;

  logic [12:0] a_crc;
  logic        a_valid, a_ok, a_busy;
  logic [14:0] a_bf;
  logic [31:0] b_crc;
  logic        b_valid, b_ok, b_busy;
  logic [14:0] b_bf;

  canxl_crc_unit u_a (
    .clk(clk), .g_rst(g_rst), .data(data), .bit_cnt(bit_cnt), .start(start),
    .accum_en(accum_en), .stuff_bit(stuff_bit), .check_req(check_req),
    .rx_crc(rx_crc), .abort(abort), .crc_out(a_crc), .crc_valid(a_valid),
    .crc_ok(a_ok), .busy(a_busy), .bits_folded(a_bf)
  );

  canxl_crc_unit #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .CNT_W(15)
  ) u_b (
    .clk(clk), .g_rst(g_rst), .data(data), .bit_cnt(bit_cnt), .start(start),
    .accum_en(accum_en), .stuff_bit(stuff_bit), .check_req(check_req),
    .rx_crc(rx_crc32), .abort(abort), .crc_out(b_crc), .crc_valid(b_valid),
    .crc_ok(b_ok), .busy(b_busy), .bits_folded(b_bf)
  );

  always #5 clk = ~clk;

  localparam int S_CRC = 0, S_VALID = 1, S_OK = 2, S_BUSY = 3, S_BF = 4,
                 S_BCRC = 5, S_BBF = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [12:0] m_crc;

  function automatic logic [12:0] fold13(input logic [12:0] c, input logic d);
    logic fb;
    fb = d ^ c[12];
    return {c[11:0], 1'b0} ^ (fb ? 13'h19C7 : 13'h0);
  endfunction

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_CRC:   return {19'h0, a_crc};
      S_VALID: return {31'h0, a_valid};
      S_OK:    return {31'h0, a_ok};
      S_BUSY:  return {31'h0, a_busy};
      S_BF:    return {17'h0, a_bf};
      S_BCRC:  return b_crc;
      S_BBF:   return {17'h0, b_bf};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic do_start();
    start = 1'b1;
    expect_val("start_busy", S_BUSY, 1);
    expect_val("start_crc", S_CRC, 0);
    expect_val("start_valid", S_VALID, 0);
    tick();
    start = 1'b0;
    m_crc = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    g_rst = 1'b0;
    expect_val("rst_crc", S_CRC, 0);
    expect_val("rst_valid", S_VALID, 0);
    expect_val("rst_ok", S_OK, 0);
    expect_val("rst_busy", S_BUSY, 0);
    expect_val("rst_bf", S_BF, 0);
    tick();

    // Two folds from INIT=0, then a matching compare.
    accum_en = 1'b1;
    do_start();
    bit_cnt = 1; data = 1'b1;
    m_crc = fold13(m_crc, 1'b1);
    expect_val("fold1_const", S_CRC, 32'h19C7);
    expect_val("fold1_model", S_CRC, m_crc);
    expect_val("fold1_bf", S_BF, 1);
    tick();
    bit_cnt = 2; data = 1'b0;
    m_crc = fold13(m_crc, 1'b0);
    expect_val("fold2_const", S_CRC, 32'h0A49);
    expect_val("fold2_bf", S_BF, 2);
    tick();
    check_req = 1'b1; rx_crc = 13'h0A49;
    expect_val("chk_valid", S_VALID, 1);
    expect_val("chk_ok", S_OK, 1);
    expect_val("chk_busy", S_BUSY, 0);
    tick();
    check_req = 1'b0;
    bit_cnt = 3; data = 1'b1;
    expect_val("done_frozen", S_CRC, 32'h0A49);
    expect_val("done_valid_hold", S_VALID, 1);
    tick();

    // Restart from DONE and compare against a wrong value.
    do_start();
    bit_cnt = 4; data = 1'b1; tick();
    bit_cnt = 5; data = 1'b0; tick();
    check_req = 1'b1; rx_crc = 13'h0A48;
    expect_val("bad_valid", S_VALID, 1);
    expect_val("bad_ok", S_OK, 0);
    tick();
    check_req = 1'b0;

    // Held counter folds once; stuff bit is skipped.
    do_start();
    bit_cnt = 6; data = 1'b1;
    m_crc = fold13(m_crc, 1'b1);
    for (int i = 0; i < 10; i++) begin
      expect_val("hold_crc", S_CRC, m_crc);
      expect_val("hold_bf", S_BF, 1);
      tick();
    end
    bit_cnt = 7; data = 1'b1; stuff_bit = 1'b1;
    expect_val("stuff_crc", S_CRC, m_crc);
    expect_val("stuff_bf", S_BF, 1);
    tick();
    stuff_bit = 1'b0;
    expect_val("stuff_after", S_BF, 1);
    tick();
    bit_cnt = 8; data = 1'b0;
    m_crc = fold13(m_crc, 1'b0);
    expect_val("fold_after_stuff", S_CRC, m_crc);
    expect_val("fold_after_stuff_bf", S_BF, 2);
    tick();

    // check_req coinciding with a strobe: pre-strobe value is compared.
    bit_cnt = 9; data = 1'b1; check_req = 1'b1; rx_crc = m_crc;
    expect_val("cs_ok", S_OK, 1);
    expect_val("cs_crc", S_CRC, m_crc);
    expect_val("cs_bf", S_BF, 2);
    tick();
    check_req = 1'b0;
    for (int i = 10; i < 13; i++) begin
      bit_cnt = 15'(i);
      expect_val("cs_frozen", S_CRC, m_crc);
      tick();
    end

    // Abort mid-ACCUM, then clean restart.
    do_start();
    bit_cnt = 20; data = 1'b1; tick();
    abort = 1'b1;
    expect_val("abort_crc", S_CRC, 0);
    expect_val("abort_valid", S_VALID, 0);
    expect_val("abort_busy", S_BUSY, 0);
    expect_val("abort_bf", S_BF, 0);
    tick();
    abort = 1'b0;
    do_start();
    bit_cnt = 21; data = 1'b1;
    expect_val("post_abort_crc", S_CRC, 32'h19C7);
    expect_val("post_abort_bf", S_BF, 1);
    tick();

    // Asynchronous reset mid-ACCUM.
    #2;
    g_rst = 1'b1;
    #1;
    expect_val("grst_crc", S_CRC, 0);
    expect_val("grst_busy", S_BUSY, 0);
    expect_val("grst_bf", S_BF, 0);
    drain();
    tick();
    g_rst = 1'b0;
    bit_cnt = 22;
    expect_val("grst_nostart", S_CRC, 0);
    expect_val("grst_nostart_busy", S_BUSY, 0);
    tick();
    do_start();
    bit_cnt = 23; data = 1'b1;
    expect_val("post_grst_crc", S_CRC, 32'h19C7);
    tick();

    // 32-bit instance, counter wrap, and bits_folded saturation.
    bit_cnt = 15'h7FFF;
    expect_val("b_start_crc", S_BCRC, 32'hFFFFFFFF);
    do_start();
    bit_cnt = 15'h0; data = 1'b1;
    expect_val("b_wrap_crc", S_BCRC, 32'hFFFFFFFE);
    expect_val("b_wrap_bf", S_BBF, 1);
    tick();
    data = 1'b0;
    for (int i = 1; i < 32767; i++) begin
      bit_cnt = 15'(i);
      tick();
    end
    bit_cnt = 15'h7FFF;
    expect_val("b_bf_max", S_BBF, 32'h7FFF);
    tick();
    bit_cnt = 15'h0;
    expect_val("a_bf_sat", S_BF, 32'h7FFF);
    expect_val("b_bf_sat", S_BBF, 32'h7FFF);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
